imm_gen_pipe: RTL and testbench

- Registered, handshaked immediate generator for the decode stage of the RV32I/RV64I datapath.
- Accepts one instruction per cycle over valid/ready and decodes the full RISC-V immediate set, including correct shift-amount and CSR forms.
- Generalised to XLEN 32/64 and carries a sideband tag.
- A 2-entry skid buffer gives full throughput under backpressure; a saturating counter tracks illegal encodings.

---
 rtl/imm_gen_pipe.sv | 188 ++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered, handshaked RISC-V immediate generator for the
// decode stage (RV32I/RV64I). One instruction per cycle is decoded into its
// immediate, format code and an illegal flag. The result is returned with a
// sideband tag through an output register backed by a one-entry skid
// register, so the block keeps full throughput under backpressure.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake; in_ready is a registered signal
//   instr, in_tag         instruction word and passthrough tag
//   out_valid / out_ready output handshake
//   imm, fmt, illegal     decoded immediate (XLEN), format code, illegal flag
//   out_tag               tag paired with the result
//   illegal_cnt           saturating count of illegal results delivered
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       fmt,
    output logic             illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] illegal_cnt
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;
    localparam logic [2:0] FMT_CSR   = 3'd7;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    // Stage p0: combinational decode of the presented instruction.
    // Every immediate form fits in 32 bits, so it is built as a signed 32-bit
    // value and sign-extended once to XLEN; zero-extended forms (shamt, CSR)
    // have bit 31 clear so the extension leaves them positive.
    logic signed [31:0]     imm32_p0;
    logic        [2:0]      fmt_p0;
    logic                   ill_p0;
    logic        [XLEN-1:0] imm_p0;
    logic        [2:0]      funct3;

    assign funct3 = instr[14:12];

    always_comb begin
        imm32_p0 = '0;
        fmt_p0   = FMT_NONE;
        ill_p0   = 1'b0;
        case (instr[6:0])
            7'b0110011: ;
            7'b0000011, 7'b1100111: begin
                imm32_p0 = {{20{instr[31]}}, instr[31:20]};
                fmt_p0   = FMT_I;
            end
            7'b0010011: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    fmt_p0 = FMT_SHAMT;
                    if (XLEN == 32) begin
                        imm32_p0 = {27'b0, instr[24:20]};
                        if (instr[25]) ill_p0 = 1'b1;
                    end else begin
                        imm32_p0 = {26'b0, instr[25:20]};
                    end
                    // slli takes no funct7 bits; srli/srai differ only in bit 30
                    if (funct3 == 3'b001 && instr[31:26] != 6'b000000)
                        ill_p0 = 1'b1;
                    if (funct3 == 3'b101 && instr[31:26] != 6'b000000 &&
                        instr[31:26] != 6'b010000)
                        ill_p0 = 1'b1;
                end else begin
                    imm32_p0 = {{20{instr[31]}}, instr[31:20]};
                    fmt_p0   = FMT_I;
                end
            end
            7'b0100011: begin
                imm32_p0 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                fmt_p0   = FMT_S;
            end
            7'b1100011: begin
                imm32_p0 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
                fmt_p0   = FMT_B;
            end
            7'b0110111, 7'b0010111: begin
                imm32_p0 = {instr[31:12], 12'b0};
                fmt_p0   = FMT_U;
            end
            7'b1101111: begin
                imm32_p0 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
                fmt_p0   = FMT_J;
            end
            7'b1110011: begin
                imm32_p0 = {20'b0, instr[31:20]};
                fmt_p0   = FMT_CSR;
            end
            default: ill_p0 = 1'b1;
        endcase
    end

    assign imm_p0 = XLEN'(imm32_p0);

    // Stage p1: output register; p2: skid register (holds the entry accepted
    // while the output was stalled). The skid is only ever full when the
    // output register is also full.
    logic [XLEN-1:0]  imm_p1, imm_p2;
    logic [2:0]       fmt_p1, fmt_p2;
    logic             ill_p1, ill_p2;
    logic [TAG_W-1:0] tag_p1, tag_p2;
    logic             vld_p1, vld_p2;
    logic [CNT_W-1:0] cnt;
    logic             accept, consume;

    assign in_ready = ~vld_p2;
    assign accept   = in_valid & ~vld_p2;
    assign consume  = vld_p1 & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            imm_p1 <= '0;
            fmt_p1 <= FMT_NONE;
            ill_p1 <= 1'b0;
            tag_p1 <= '0;
            imm_p2 <= '0;
            fmt_p2 <= FMT_NONE;
            ill_p2 <= 1'b0;
            tag_p2 <= '0;
            cnt    <= '0;
        end else begin
            if (vld_p2) begin
                if (consume) begin
                    imm_p1 <= imm_p2;
                    fmt_p1 <= fmt_p2;
                    ill_p1 <= ill_p2;
                    tag_p1 <= tag_p2;
                    vld_p2 <= 1'b0;
                end
            end else if (accept) begin
                if (!vld_p1 || consume) begin
                    imm_p1 <= imm_p0;
                    fmt_p1 <= fmt_p0;
                    ill_p1 <= ill_p0;
                    tag_p1 <= in_tag;
                    vld_p1 <= 1'b1;
                end else begin
                    imm_p2 <= imm_p0;
                    fmt_p2 <= fmt_p0;
                    ill_p2 <= ill_p0;
                    tag_p2 <= in_tag;
                    vld_p2 <= 1'b1;
                end
            end else if (consume) begin
                vld_p1 <= 1'b0;
            end
            // counted on delivery so a result discarded by reset is never counted
            if (consume && ill_p1) cnt <= sat_inc(cnt);
        end
    end

    assign out_valid   = vld_p1;
    assign imm         = imm_p1;
    assign fmt         = fmt_p1;
    assign illegal     = ill_p1;
    assign out_tag     = tag_p1;
    assign illegal_cnt = cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

    logic        clk, rst_n, in_valid, out_ready;
    logic [31:0] instr, in_tag;
    logic        rdy_a, rdy_b, rdy_c, ov_a, ov_b, ov_c;
    logic [31:0] imm_a, imm_c;
    logic [63:0] imm_b;
    logic [2:0]  fmt_a, fmt_b, fmt_c;
    logic        ill_a, ill_b, ill_c;
    logic [31:0] tag_a, tag_b, tag_c;
    logic [15:0] cnt_a, cnt_b;
    logic [1:0]  cnt_c;

    // a: XLEN=32, b: XLEN=64, c: XLEN=32 with a 2-bit counter
    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a),
        .instr(instr), .in_tag(in_tag), .out_valid(ov_a), .out_ready(out_ready),
        .imm(imm_a), .fmt(fmt_a), .illegal(ill_a), .out_tag(tag_a), .illegal_cnt(cnt_a));
    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b),
        .instr(instr), .in_tag(in_tag), .out_valid(ov_b), .out_ready(out_ready),
        .imm(imm_b), .fmt(fmt_b), .illegal(ill_b), .out_tag(tag_b), .illegal_cnt(cnt_b));
    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .CNT_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_c),
        .instr(instr), .in_tag(in_tag), .out_valid(ov_c), .out_ready(out_ready),
        .imm(imm_c), .fmt(fmt_c), .illegal(ill_c), .out_tag(tag_c), .illegal_cnt(cnt_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm32;
        logic [63:0] imm64;
        logic [2:0]  fmt;
        logic        ill32;
        logic        ill64;
        logic        dc32;   // imm/fmt not checked at XLEN=32 (malformed shift)
        logic        dc64;
    } vec_t;

    localparam int NV = 18;
    vec_t vt[NV];

    int n_pass = 0;
    int n_tot  = 0;
    int ca = 0, cb = 0, cc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string nm);
        chk({nm, "_cnt_a"}, 64'(cnt_a), 64'(ca));
        chk({nm, "_cnt_b"}, 64'(cnt_b), 64'(cb));
        chk({nm, "_cnt_c"}, 64'(cnt_c), 64'(cc));
    endtask

    task automatic model_xfer(input int i);
        if (vt[i].ill32) ca++;
        if (vt[i].ill64) cb++;
        if (vt[i].ill32 && cc < 3) cc++;
    endtask

    task automatic chk_vec(input string nm, input int i, input logic [31:0] tag);
        chk({nm, "_valid"}, 64'({ov_a, ov_b, ov_c}), 64'h7);
        if (!vt[i].dc32) begin
            chk({nm, "_imm32"}, 64'(imm_a), vt[i].imm32);
            chk({nm, "_imm32c"}, 64'(imm_c), vt[i].imm32);
            chk({nm, "_fmt32"}, 64'(fmt_a), 64'(vt[i].fmt));
        end
        if (!vt[i].dc64) begin
            chk({nm, "_imm64"}, imm_b, vt[i].imm64);
            chk({nm, "_fmt64"}, 64'(fmt_b), 64'(vt[i].fmt));
        end
        chk({nm, "_ill"}, 64'({ill_a, ill_c, ill_b}),
            64'({vt[i].ill32, vt[i].ill32, vt[i].ill64}));
        chk({nm, "_tag"}, {tag_a, tag_b}, {tag, tag});
        chk({nm, "_tagc"}, 64'(tag_c), 64'(tag));
    endtask

    int          q_idx[$];
    logic [31:0] q_tag[$];

    initial begin
        vt[0]  = '{32'hFFF00093, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{32'hFE000EE3, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{32'h123450B7, 64'h1234_5000, 64'h0000_0000_1234_5000, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{32'h4030D093, 64'h3,         64'h3,                   3'd6, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{32'h800000B7, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{32'h03F09093, 64'h0,         64'h3F,                  3'd6, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[6]  = '{32'h300020F3, 64'h300,       64'h300,                 3'd7, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{32'h0000007F, 64'h0,         64'h0,                   3'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[8]  = '{32'h00B50533, 64'h0,         64'h0,                   3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{32'hFE512C23, 64'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[10] = '{32'hFFDFF06F, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[11] = '{32'h0045A503, 64'h4,         64'h4,                   3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[12] = '{32'hFFFFF117, 64'hFFFF_F000, 64'hFFFF_FFFF_FFFF_F000, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[13] = '{32'h8030D093, 64'h0,         64'h0,                   3'd6, 1'b1, 1'b1, 1'b1, 1'b1};
        vt[14] = '{32'h40109093, 64'h0,         64'h0,                   3'd6, 1'b1, 1'b1, 1'b1, 1'b1};
        vt[15] = '{32'h00000001, 64'h0,         64'h0,                   3'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[16] = '{32'h00008067, 64'h0,         64'h0,                   3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[17] = '{32'h7FF00093, 64'h7FF,       64'h7FF,                 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b1; in_valid = 1'b0; instr = '0; in_tag = '0; out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #4;
        chk("rst_valid", 64'({ov_a, ov_b, ov_c}), 64'h0);
        chk("rst_imm", {imm_a, 32'(imm_b)}, 64'h0);
        chk("rst_imm_hi", {imm_b[63:32], imm_c}, 64'h0);
        chk("rst_fmt_ill", 64'({fmt_a, fmt_b, fmt_c, ill_a, ill_b, ill_c}), 64'h0);
        chk("rst_tag", {tag_a, tag_b}, 64'h0);
        chk_cnt("rst");
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 64'({rdy_a, rdy_b, rdy_c}), 64'h7);

        // back-to-back table, out_ready=1: each result one cycle after accept
        in_valid = 1'b1;
        for (int i = 0; i < NV; i++) begin
            instr  = vt[i].instr;
            in_tag = 32'hA000_0000 + 32'(i);
            tick();
            chk_vec($sformatf("vec%0d", i), i, 32'hA000_0000 + 32'(i));
            chk_cnt($sformatf("vec%0d", i));
            model_xfer(i);
        end
        in_valid = 1'b0;
        tick();
        chk("tbl_drained", 64'({ov_a, ov_b, ov_c}), 64'h0);
        chk_cnt("tbl_end");
        chk("tbl_sat", 64'(cnt_c), 64'h3);

        // backpressure: two accepted while stalled, third held off
        out_ready = 1'b0;
        in_valid = 1'b1; instr = vt[2].instr; in_tag = 32'hB0;
        tick();
        chk_vec("bp_a", 2, 32'hB0);
        chk("bp_rdy1", 64'(rdy_a), 64'h1);
        instr = vt[6].instr; in_tag = 32'hB1;
        tick();
        chk("bp_rdy_full", 64'({rdy_a, rdy_b, rdy_c}), 64'h0);
        chk_vec("bp_hold1", 2, 32'hB0);
        instr = vt[7].instr; in_tag = 32'hB2;
        tick();
        chk("bp_rdy_full2", 64'(rdy_a), 64'h0);
        chk_vec("bp_hold2", 2, 32'hB0);
        tick();
        chk_vec("bp_hold3", 2, 32'hB0);
        out_ready = 1'b1;
        tick();
        chk_vec("bp_b", 6, 32'hB1);
        chk("bp_rdy_back", 64'(rdy_a), 64'h1);
        tick();
        chk_vec("bp_c", 7, 32'hB2);
        in_valid = 1'b0;
        model_xfer(7);
        tick();
        chk("bp_drained", 64'(ov_a), 64'h0);
        chk_cnt("bp_end");

        // reset with the skid full discards both entries
        out_ready = 1'b0;
        in_valid = 1'b1; instr = vt[7].instr; in_tag = 32'hC0;
        tick();
        instr = vt[15].instr; in_tag = 32'hC1;
        tick();
        in_valid = 1'b0;
        chk("rs_full", 64'(rdy_a), 64'h0);
        #2 rst_n = 1'b0;
        #1;
        ca = 0; cb = 0; cc = 0;
        chk("rs_valid", 64'({ov_a, ov_b, ov_c}), 64'h0);
        chk_cnt("rs_async");
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("rs_ready", 64'({rdy_a, rdy_b, rdy_c}), 64'h7);
        tick();
        chk("rs_empty", 64'({ov_a, ov_b, ov_c}), 64'h0);
        chk_cnt("rs_after");

        // random valid/ready against the table as reference
        begin
            int          sent = 0, got = 0, cyc = 0, idx = 0;
            bit          held = 0, fired;
            logic [63:0] h_imm;
            logic [31:0] h_imm_a, h_tag;
            logic [3:0]  h_fi;
            while (got < 1000 && cyc < 20000) begin
                cyc++;
                if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
                    idx = int'($urandom_range(0, NV - 1));
                    instr = vt[idx].instr;
                    in_tag = $urandom;
                    in_valid = 1'b1;
                end
                out_ready = ($urandom_range(0, 2) != 0);
                @(negedge clk);
                if (held) begin
                    chk("rnd_stable", {h_imm_a, h_tag}, {imm_a, tag_a});
                    chk("rnd_stable64", h_imm, imm_b);
                    chk("rnd_stable_f", 64'(h_fi), 64'({ov_a, fmt_a}));
                end
                held = ov_a && !out_ready;
                h_imm_a = imm_a; h_imm = imm_b; h_tag = tag_a; h_fi = {ov_a, fmt_a};
                if (ov_a && out_ready) begin
                    n_tot++;
                    if (q_idx.size() == 0) begin
                        $display("FAIL rnd_xfer: got unexpected output tag 0x%0h, required none", tag_a);
                    end else begin
                        int          ei;
                        logic [31:0] et;
                        bit          ok;
                        ei = q_idx.pop_front();
                        et = q_tag.pop_front();
                        ok = (tag_a === et) && (tag_b === et) && (ill_a === vt[ei].ill32) &&
                             (ill_b === vt[ei].ill64) && ov_b;
                        if (!vt[ei].dc32)
                            ok = ok && (64'(imm_a) === vt[ei].imm32) && (fmt_a === vt[ei].fmt);
                        if (!vt[ei].dc64)
                            ok = ok && (imm_b === vt[ei].imm64) && (fmt_b === vt[ei].fmt);
                        if (ok) n_pass++;
                        else $display("FAIL rnd_xfer: got tag 0x%0h imm 0x%0h/0x%0h fmt %0d ill %0d, required tag 0x%0h imm 0x%0h/0x%0h fmt %0d ill %0d",
                                      tag_a, imm_a, imm_b, fmt_a, ill_a, et,
                                      vt[ei].imm32, vt[ei].imm64, vt[ei].fmt, vt[ei].ill32);
                        model_xfer(ei);
                    end
                    got++;
                end
                fired = in_valid && rdy_a;
                if (fired) begin
                    q_idx.push_back(idx);
                    q_tag.push_back(in_tag);
                    sent++;
                end
                @(posedge clk);
                #1;
                if (fired) in_valid = 1'b0;
            end
            in_valid = 1'b0;
            chk("rnd_count", 64'(got), 64'd1000);
            chk("rnd_queue_empty", 64'(q_idx.size()), 64'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("rnd_idle", 64'({ov_a, ov_b, ov_c}), 64'h0);
        chk_cnt("rnd_end");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
